// File: rtl/ring_osc_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronized osc_in rising edges over a gate window of clk cycles.
// Define FREQ_METER_CONT_EN for level-sensitive start and back-to-back windows.
module ring_osc_freq_meter #(
  parameter int GATE_W      = 16,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              osc_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

  state_t             state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               hist_q;
  logic               osc_rise;
  logic [GATE_W-1:0]  gate_cnt;
  logic               start_go;

  // Synchronizer chain plus one history flop for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign osc_rise = sync_q[SYNC_STAGES-1] & ~hist_q;

`ifdef FREQ_METER_CONT_EN
  assign start_go = start;
`else
  logic start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_q <= 1'b0;
    else        start_q <= start;
  end

  assign start_go = start & ~start_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_go) state_nxt = ARM;
      ARM:     state_nxt = (gate_len == '0) ? DONE : MEASURE;
      MEASURE: if (gate_cnt == GATE_W'(1)) state_nxt = DONE;
`ifdef FREQ_METER_CONT_EN
      DONE:    state_nxt = start ? ARM : IDLE;
`else
      DONE:    state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Gate window counter and saturating edge counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ARM: begin
          gate_cnt <= gate_len;
          count    <= '0;
          overflow <= 1'b0;
        end
        MEASURE: begin
          gate_cnt <= gate_cnt - GATE_W'(1);
          if (osc_rise) begin
            if (count == {CNT_W{1'b1}}) overflow <= 1'b1;
            else                        count    <= count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ARM) || (state == MEASURE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Scoreboard bench for ring_osc_freq_meter: a 16-bit instance and a saturating 4-bit instance share stimulus.
// Continuous-mode expectations are selected by FREQ_METER_CONT_EN.
module tb_ring_osc_freq_meter;

  typedef struct {
    int     lo;
    int     hi;
    int     slo;
    int     shi;
    bit     sovf;
    int     busy_len;
    int     at;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] gate_len = '0;
  logic        osc_free = 1'b0;
  logic        osc_man = 1'b0;
  logic        free_run = 1'b1;
  logic        osc_in;

  logic        busy, done, overflow;
  logic [15:0] count;
  logic        busy_s, done_s, ovf_s;
  logic [3:0]  count_s;

  exp_t exp_q[$];
  exp_t e;
  int   cyc = 0;
  int   busy_run = 0;
  int   errors = 0;
  int   checks = 0;

  assign osc_in = free_run ? osc_free : osc_man;

  ring_osc_freq_meter #(.GATE_W(16), .CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .start(start), .gate_len(gate_len),
    .busy(busy), .done(done), .count(count), .overflow(overflow)
  );

  ring_osc_freq_meter #(.GATE_W(16), .CNT_W(4), .SYNC_STAGES(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .start(start), .gate_len(gate_len),
    .busy(busy_s), .done(done_s), .count(count_s), .overflow(ovf_s)
  );

  always #2 clk = ~clk;

  // Oscillator edges land on odd ns so they never coincide with a clk edge
  initial begin
    #1;
    forever #10 osc_free = ~osc_free;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string name, input bit ok, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst_n)     busy_run = 0;
    else if (busy)  busy_run++;
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1'b0, 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("done_cycle", cyc == e.at, cyc, e.at);
        check("count", int'(count) >= e.lo && int'(count) <= e.hi, int'(count), e.lo);
        check("overflow", overflow == 1'b0, int'(overflow), 0);
        check("sat_done", done_s == 1'b1, int'(done_s), 1);
        check("sat_count", int'(count_s) >= e.slo && int'(count_s) <= e.shi, int'(count_s), e.slo);
        check("sat_overflow", ovf_s == e.sovf, int'(ovf_s), int'(e.sovf));
        check("busy_len", busy_run == e.busy_len, busy_run, e.busy_len);
      end
      busy_run = 0;
    end
  end

  task automatic applyStimulus(input int gl, input int lo, input int hi,
                               input int slo, input int shi, input bit sovf);
    exp_t x;
    @(negedge clk);
    gate_len = 16'(gl);
    start    = 1'b1;
    x.lo = lo; x.hi = hi; x.slo = slo; x.shi = shi; x.sovf = sovf;
    x.busy_len = gl + 1;
    x.at = cyc + 2 + gl;
    exp_q.push_back(x);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_busy"}, busy == 1'b0, int'(busy), 0);
    check({tag, "_done"}, done == 1'b0, int'(done), 0);
    check({tag, "_count"}, count == '0, int'(count), 0);
    check({tag, "_overflow"}, overflow == 1'b0, int'(overflow), 0);
    check({tag, "_sat_count"}, count_s == '0, int'(count_s), 0);
    check({tag, "_sat_overflow"}, ovf_s == 1'b0, int'(ovf_s), 0);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain", exp_q.size() == 0, exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic burst(input int n);
    for (int i = 0; i < n; i++) begin
      osc_man = 1'b1;
      repeat (2) @(negedge clk);
      osc_man = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    int base;
    // Reset holds everything at zero while the oscillator runs
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset");
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Free-running oscillator: 20 ns period, 4 ns clk
    applyStimulus(100, 19, 21, 15, 15, 1'b1);
    waitDrain(200);
    applyStimulus(0, 0, 0, 0, 0, 1'b0);
    waitDrain(20);
    applyStimulus(200, 39, 41, 15, 15, 1'b1);
    waitDrain(300);

    // Exact edge counts from hand-placed pulses, around the 4-bit saturation point
    free_run = 1'b0;
    osc_man  = 1'b0;
    repeat (4) @(negedge clk);
    applyStimulus(20, 4, 4, 4, 4, 1'b0);
    burst(4);
    waitDrain(50);
    applyStimulus(70, 15, 15, 15, 15, 1'b0);
    burst(15);
    waitDrain(50);
    applyStimulus(70, 16, 16, 15, 15, 1'b1);
    burst(16);
    waitDrain(50);
    free_run = 1'b1;

    // A second start and a gate_len change mid-window are ignored
    applyStimulus(100, 19, 21, 15, 15, 1'b1);
    repeat (30) @(negedge clk);
    start    = 1'b1;
    gate_len = 16'd5;
    @(negedge clk);
    start = 1'b0;
    waitDrain(200);
    repeat (20) @(negedge clk);

    // Reset 50 cycles into MEASURE abandons the window
    applyStimulus(100, 19, 21, 15, 15, 1'b1);
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("midreset");
    repeat (3) begin
      @(negedge clk);
      checkOutput("midreset_hold");
    end
    rst_n = 1'b1;
    repeat (120) @(negedge clk);
    applyStimulus(100, 19, 21, 15, 15, 1'b1);
    waitDrain(200);

    // start held high for several windows
    @(negedge clk);
    base     = cyc;
    gate_len = 16'd20;
    start    = 1'b1;
`ifdef FREQ_METER_CONT_EN
    for (int k = 0; k < 3; k++) begin
      e.lo = 3; e.hi = 5; e.slo = 3; e.shi = 5; e.sovf = 1'b0;
      e.busy_len = 21;
      e.at = base + 22 + 22 * k;
      exp_q.push_back(e);
    end
    repeat (50) @(negedge clk);
    start = 1'b0;
    waitDrain(100);
`else
    e.lo = 3; e.hi = 5; e.slo = 3; e.shi = 5; e.sovf = 1'b0;
    e.busy_len = 21;
    e.at = base + 22;
    exp_q.push_back(e);
    repeat (60) @(negedge clk);
    start = 1'b0;
    waitDrain(100);
`endif
    repeat (40) @(negedge clk);
    check("final_queue_empty", exp_q.size() == 0, exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
